life_step_engine: RTL



---
 rtl/life_pkg.sv | 13 +
 rtl/life_cell_rule.sv | 19 +
 rtl/life_step_engine.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared state type, rule constants and width helper for the life step engine
package life_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;

  localparam logic [3:0] BIRTH_N   = 4'd3;
  localparam logic [3:0] SURVIVE_N = 4'd2;

  function automatic int addr_w(input int log_w, input int log_h);
    return log_w + log_h;
  endfunction

endpackage

// File: rtl/life_cell_rule.sv
// rtl/life_cell_rule.sv - 3x3 window to next-state bit; bit 4 is the centre cell
module life_cell_rule
  import life_pkg::*;
(
  input  logic [8:0] i_window,
  output logic       o_next
);

  logic [3:0] w_n;

  always_comb begin
    w_n = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (i != 4) w_n = w_n + {3'b000, i_window[i]};
    end
    o_next = (w_n == BIRTH_N) | (i_window[4] & (w_n == SURVIVE_N));
  end

endmodule

// File: rtl/life_step_engine.sv
// rtl/life_step_engine.sv - one Game of Life generation on a toroidal board, streamed one cell per cycle
module life_step_engine
  import life_pkg::*;
#(
  parameter int LOG_W = 6,
  parameter int LOG_H = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic [LOG_W+LOG_H-1:0] rd_addr,
  input  logic                   rd_data,
  output logic                   wr_en,
  output logic [LOG_W+LOG_H-1:0] wr_addr,
  output logic                   wr_data,
  output logic [LOG_W+LOG_H:0]   pop_count
);

  localparam int W  = 1 << LOG_W;
  localparam int AW = addr_w(LOG_W, LOG_H);

  state_t           r_state, w_state_n;
  logic             r_busy, r_done;
  logic [LOG_W:0]   r_x;
  logic [1:0]       r_ld;
  logic [LOG_H-1:0] r_y, r_rd_row;
  logic             r_pv;
  logic [1:0]       r_psel;
  logic [LOG_W-1:0] r_px;
  logic [W-1:0]     r_up, r_cur, r_down, r_pf;
  logic [W-1:0]     w_up_n, w_cur_n, w_down_n, w_pf_n;
  logic [AW:0]      r_pop;
  logic [LOG_W-1:0] w_xc, w_xm, w_xp;
  logic             w_accept, w_row_end, w_wr_en, w_rule;
  logic [8:0]       w_window;

  assign w_accept  = (r_state == IDLE) & start & ~abort;
  assign w_row_end = (r_state == COMPUTE) & r_x[LOG_W];
  assign w_wr_en   = (r_state == COMPUTE) & ~r_x[LOG_W];
  assign w_xc      = r_x[LOG_W-1:0];
  assign w_xm      = w_xc - LOG_W'(1);
  assign w_xp      = w_xc + LOG_W'(1);

  assign w_window = {r_up[w_xm],   r_up[w_xc],   r_up[w_xp],
                     r_cur[w_xm],  r_cur[w_xc],  r_cur[w_xp],
                     r_down[w_xm], r_down[w_xc], r_down[w_xp]};

  life_cell_rule u_rule (
    .i_window (w_window),
    .o_next   (w_rule)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_busy  <= (w_state_n != IDLE);
      r_done  <= (r_state == DONE) & ~abort;
    end
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:    if (start) w_state_n = LOAD;
      LOAD:    if (r_ld == 2'd3) w_state_n = COMPUTE;
      COMPUTE: if (w_row_end && (r_y == '1)) w_state_n = DONE;
      DONE:    w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
    if (abort) w_state_n = IDLE;
  end

  // r_pv/r_psel/r_px delay each issued read by one cycle so its data lands in the right row register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x      <= '0;
      r_ld     <= '0;
      r_y      <= '0;
      r_rd_row <= '0;
      r_pv     <= 1'b0;
      r_psel   <= '0;
      r_px     <= '0;
      r_pop    <= '0;
    end else begin
      r_pv <= 1'b0;
      if (!abort) begin
        case (r_state)
          IDLE: if (start) begin
            r_x      <= '0;
            r_ld     <= '0;
            r_y      <= '0;
            r_rd_row <= '1;
          end
          LOAD: if (r_ld != 2'd3) begin
            r_pv   <= 1'b1;
            r_psel <= r_ld;
            r_px   <= w_xc;
            if (w_xc == '1) begin
              r_x      <= '0;
              r_ld     <= r_ld + 2'd1;
              r_rd_row <= LOG_H'(r_ld);
            end else begin
              r_x <= r_x + 1'b1;
            end
          end
          COMPUTE: if (!r_x[LOG_W]) begin
            r_pv   <= 1'b1;
            r_psel <= 2'd3;
            r_px   <= w_xc;
            r_x    <= r_x + 1'b1;
          end else begin
            r_x      <= '0;
            r_y      <= r_y + 1'b1;
            r_rd_row <= r_rd_row + 1'b1;
          end
          default: ;
        endcase
      end
      if (w_accept) r_pop <= '0;
      else if (w_wr_en & w_rule) r_pop <= r_pop + (AW+1)'(1);
    end
  end

  always_comb begin
    w_up_n   = r_up;
    w_cur_n  = r_cur;
    w_down_n = r_down;
    w_pf_n   = r_pf;
    if (r_pv) begin
      case (r_psel)
        2'd0:    w_up_n[r_px]   = rd_data;
        2'd1:    w_cur_n[r_px]  = rd_data;
        2'd2:    w_down_n[r_px] = rd_data;
        default: w_pf_n[r_px]   = rd_data;
      endcase
    end
    if (w_row_end) begin
      w_up_n   = r_cur;
      w_cur_n  = r_down;
      w_down_n = w_pf_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_up   <= '0;
      r_cur  <= '0;
      r_down <= '0;
      r_pf   <= '0;
    end else begin
      r_up   <= w_up_n;
      r_cur  <= w_cur_n;
      r_down <= w_down_n;
      r_pf   <= w_pf_n;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign rd_addr   = {r_rd_row, w_xc};
  assign wr_en     = w_wr_en;
  assign wr_addr   = {r_y, w_xc};
  assign wr_data   = w_wr_en & w_rule;
  assign pop_count = r_pop;

endmodule
